change_dispenser: RTL and testbench

Coin-change dispensing sequencer for the vending machine. On a start pulse it takes a change amount from the datapath and drives four coin hoppers (100, 50, 20, 10 sen) one coin at a time, largest denomination first. It tracks per-hopper inventory and handshakes each coin with the hopper's eject sensor. It reports shortfall or hopper faults back to the control unit.

---
 rtl/change_dispenser.sv | 114 +++++++++++
 tb/tb_change_dispenser.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// change_dispenser: greedy coin-change sequencer driving four hoppers (100/50/20/10 sen), one coin per eject/ack handshake.
// Registers update on the falling clk edge; rst is asynchronous active-low.
// Inputs : start/amount (begin paying, 10-sen units), ld_inv/inv_sel/inv_val (hopper inventory write, 0=100 sen .. 3=10 sen),
//          coin_ack (hopper eject sensor), clr_fault (leave FAULT).
// Outputs: eject (one-hot, bit3=100 sen), busy, done (1-cycle pulse), short (sticky shortfall), fault,
//          remaining (unpaid balance), empty (per-hopper inventory==0, same order as eject).
// Optional: define CHG_TIMEOUT_EN to fault when a coin is not acknowledged within TIMEOUT cycles of EJECT.
module change_dispenser #(
  parameter int AMT_W   = 8,
  parameter int INV_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             ld_inv,
  input  logic [1:0]       inv_sel,
  input  logic [INV_W-1:0] inv_val,
  input  logic             coin_ack,
  input  logic             clr_fault,
  output logic [3:0]       eject,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic             fault,
  output logic [AMT_W-1:0] remaining,
  output logic [3:0]       empty
);
  typedef enum logic [2:0] {IDLE, SELECT, EJECT, RELEASE, DONE, FAULT} state_t;
  state_t           state;
  logic [INV_W-1:0] inv [4];
  logic [1:0]       sel, pick;
  logic             found;

  function automatic logic [AMT_W-1:0] val(input logic [1:0] d);
    val = d == 2'd0 ? AMT_W'(10) : d == 2'd1 ? AMT_W'(5) : d == 2'd2 ? AMT_W'(2) : AMT_W'(1);
  endfunction

  // Scan smallest to largest so the largest usable denomination wins.
  always_comb begin
    found = 1'b0;
    pick  = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (inv[i] != '0 && val(2'(i)) <= remaining) begin
        found = 1'b1;
        pick  = 2'(i);
      end
  end

  always_comb begin
    empty = 4'b0;
    for (int i = 0; i < 4; i++) empty[3-i] = inv[i] == '0;
  end

  assign eject = state == EJECT ? 4'b1000 >> sel : 4'b0;
  assign busy  = state != IDLE;
  assign done  = state == DONE;

`ifdef CHG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmr;
  assign fault = state == FAULT;
  always_ff @(negedge clk or negedge rst)
    if (!rst) tmr <= '0;
    else tmr <= state == EJECT ? tmr + TW'(1) : '0;
`else
  localparam int unused_timeout = TIMEOUT;
  assign fault = 1'b0;
`endif

  always_ff @(negedge clk or negedge rst)
    if (!rst) begin
      state     <= IDLE;
      sel       <= 2'd0;
      remaining <= '0;
      short     <= 1'b0;
      for (int i = 0; i < 4; i++) inv[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ld_inv) inv[inv_sel] <= inv_val;
          if (start) begin
            remaining <= amount;
            short     <= 1'b0;
            state     <= SELECT;
          end
        end
        SELECT:
          if (remaining == '0) state <= DONE;
          else if (found) begin
            sel   <= pick;
            state <= EJECT;
          end else begin
            short <= 1'b1;
            state <= DONE;
          end
        EJECT:
          if (coin_ack) state <= RELEASE;
`ifdef CHG_TIMEOUT_EN
          else if (tmr == TW'(TIMEOUT - 1)) state <= FAULT;
`endif
        RELEASE:
          if (!coin_ack) begin
            remaining <= remaining - val(sel);
            inv[sel]  <= inv[sel] - INV_W'(1);
            state     <= SELECT;
          end
        DONE:    state <= IDLE;
        FAULT:   if (clr_fault) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed self-checking bench for change_dispenser.
module tb_change_dispenser;
  logic       clk = 1'b0, rst = 1'b0, start = 1'b0, ld_inv = 1'b0, coin_ack = 1'b0, clr_fault = 1'b0;
  logic [7:0] amount = '0, inv_val = '0, remaining;
  logic [1:0] inv_sel = '0;
  logic [3:0] eject, empty;
  logic       busy, done, short, fault;
  int         n_cmp = 0, n_bad = 0;

  change_dispenser #(.AMT_W(8), .INV_W(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .amount(amount), .ld_inv(ld_inv), .inv_sel(inv_sel),
    .inv_val(inv_val), .coin_ack(coin_ack), .clr_fault(clr_fault), .eject(eject), .busy(busy),
    .done(done), .short(short), .fault(fault), .remaining(remaining), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ld(input logic [1:0] s, input logic [7:0] v);
    ld_inv = 1'b1; inv_sel = s; inv_val = v;
    @(posedge clk);
    ld_inv = 1'b0;
  endtask

  task automatic go(input logic [7:0] a);
    start = 1'b1; amount = a;
    @(posedge clk);
    start = 1'b0;
    chk("sel_busy", busy, 1);
    chk("sel_eject", eject, 0);
  endtask

  task automatic coin(input string tag, input logic [3:0] exp);
    int k = 0;
    while (eject == 4'b0 && k < 20) begin
      @(posedge clk);
      k++;
    end
    chk(tag, eject, exp);
    coin_ack = 1'b1;
    @(posedge clk);
    chk({tag, "_rel"}, eject, 0);
    coin_ack = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 40) begin
      @(posedge clk);
      k++;
    end
    chk("done", done, 1);
    @(posedge clk);
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    @(posedge clk);
    chk("rst_eject", eject, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_short", short, 0);
    chk("rst_fault", fault, 0);
    chk("rst_rem", remaining, 0);
    chk("rst_empty", empty, 4'b1111);
    rst = 1'b1;

    for (int i = 0; i < 4; i++) ld(2'(i), 8'd10);
    chk("t1_empty0", empty, 4'b0000);
    go(8'd18);
    coin("t1_c100", 4'b1000);
    coin("t1_c50", 4'b0100);
    coin("t1_c20", 4'b0010);
    coin("t1_c10", 4'b0001);
    wait_done();
    chk("t1_rem", remaining, 0);
    chk("t1_short", short, 0);
    chk("t1_empty", empty, 4'b0000);

    ld(2'd0, 8'd0);
    for (int i = 1; i < 4; i++) ld(2'(i), 8'd5);
    go(8'd10);
    chk("t2_empty_a", empty[3], 1);
    coin("t2_c50a", 4'b0100);
    chk("t2_empty_b", empty[3], 1);
    coin("t2_c50b", 4'b0100);
    chk("t2_empty_c", empty[3], 1);
    wait_done();
    chk("t2_rem", remaining, 0);
    chk("t2_short", short, 0);

    ld(2'd2, 8'd0);
    ld(2'd3, 8'd0);
    ld_inv = 1'b1; inv_sel = 2'd1; inv_val = 8'd1;
    go(8'd7);
    ld_inv = 1'b0;
    coin("t3_c50", 4'b0100);
    wait_done();
    chk("t3_short", short, 1);
    chk("t3_rem", remaining, 2);
    chk("t3_empty", empty, 4'b1111);
    @(posedge clk);
    chk("t3_short_sticky", short, 1);

    go(8'd0);
    chk("t4_done_sel", done, 0);
    @(posedge clk);
    chk("t4_done", done, 1);
    chk("t4_busy", busy, 1);
    chk("t4_eject", eject, 0);
    @(posedge clk);
    chk("t4_done_off", done, 0);
    chk("t4_busy_off", busy, 0);
    chk("t4_short", short, 0);

    for (int i = 0; i < 4; i++) ld(2'(i), 8'd3);
    go(8'd12);
    start = 1'b1; amount = 8'd5; ld_inv = 1'b1; inv_sel = 2'd3; inv_val = 8'd0;
    @(posedge clk);
    start = 1'b0; ld_inv = 1'b0;
    chk("t5_eject", eject, 4'b1000);
    chk("t5_rem_kept", remaining, 12);
    chk("t5_inv_kept", empty, 4'b0000);
    coin_ack = 1'b1;
    @(posedge clk);
    chk("t5_rel_eject", eject, 0);
    chk("t5_rel_busy", busy, 1);
    #1 rst = 1'b0;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_eject", eject, 0);
    chk("t5_rst_empty", empty, 4'b1111);
    chk("t5_rst_short", short, 0);
    chk("t5_rst_rem", remaining, 0);
    coin_ack = 1'b0;
    @(posedge clk);
    rst = 1'b1;

`ifdef CHG_TIMEOUT_EN
    ld(2'd3, 8'd2);
    go(8'd1);
    @(posedge clk);
    chk("t6_eject", eject, 4'b0001);
    repeat (15) @(posedge clk);
    chk("t6_eject16", eject, 4'b0001);
    chk("t6_nofault", fault, 0);
    @(posedge clk);
    chk("t6_fault", fault, 1);
    chk("t6_drop", eject, 0);
    chk("t6_busy", busy, 1);
    start = 1'b1; amount = 8'd9;
    @(posedge clk);
    start = 1'b0;
    chk("t6_start_ign", fault, 1);
    chk("t6_rem", remaining, 1);
    clr_fault = 1'b1;
    @(posedge clk);
    clr_fault = 1'b0;
    chk("t6_clr_fault", fault, 0);
    chk("t6_clr_busy", busy, 0);
    chk("t6_clr_rem", remaining, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
